// File: rtl/button_debouncer.sv
// Push-button conditioner: two-flop synchronizer, prescaled sampling, stability
// filter, and a short/long press classifier producing one-clk event pulses.
module button_debouncer #(
  parameter int SAMPLE_DIV   = 16,
  parameter int STABLE_CNT   = 4,
  parameter int LONG_SAMPLES = 256,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse
);

  localparam int CNT_W  = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
  localparam int HOLD_W = $clog2(LONG_SAMPLES);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_CNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_SAMPLES - 1);

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_PRESSED  = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  logic                  sync1_r, sync2_r;
  logic [SAMPLE_DIV-1:0] presc_r;
  logic [CNT_W-1:0]      stab_r;
  logic                  level_r, press_r, release_r, short_r, long_r;
  logic [HOLD_W-1:0]     hold_r, hold_nx_s;
  state_t                state_r, state_nx_s;
  logic                  short_nx_s, long_nx_s;
  logic                  tick_s, raw_s, differ_s, flip_s, rise_s, fall_s;

  assign tick_s   = &presc_r;
  assign raw_s    = sync2_r ^ ACTIVE_LOW;
  assign differ_s = raw_s != level_r;
  assign flip_s   = tick_s & differ_s & (stab_r == CNT_MAX);
  assign rise_s   = flip_s & ~level_r;
  assign fall_s   = flip_s & level_r;

  // Synchronizer and free-running sample prescaler
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_r <= ACTIVE_LOW;
      sync2_r <= ACTIVE_LOW;
      presc_r <= '0;
    end else begin
      sync1_r <= btn_in;
      sync2_r <= sync1_r;
      presc_r <= presc_r + SAMPLE_DIV'(1);
    end
  end

  // Stability filter with press/release edge pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stab_r    <= '0;
      level_r   <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      if (tick_s) begin
        if (!differ_s) begin
          stab_r <= '0;
        end else if (stab_r == CNT_MAX) begin
          level_r <= ~level_r;
          stab_r  <= '0;
        end else begin
          stab_r <= stab_r + CNT_W'(1);
        end
      end
      press_r   <= rise_s;
      release_r <= fall_s;
    end
  end

  // Press classifier: a release always beats a coincident long threshold
  always_comb begin
    state_nx_s = state_r;
    hold_nx_s  = hold_r;
    short_nx_s = 1'b0;
    long_nx_s  = 1'b0;
    case (state_r)
      ST_RELEASED: begin
        if (rise_s) begin
          state_nx_s = ST_PRESSED;
          hold_nx_s  = '0;
        end else begin
          state_nx_s = ST_RELEASED;
        end
      end
      ST_PRESSED: begin
        if (fall_s) begin
          state_nx_s = ST_RELEASED;
          short_nx_s = 1'b1;
        end else if (tick_s && level_r) begin
          if (hold_r == HOLD_MAX) begin
            state_nx_s = ST_HELD;
            long_nx_s  = 1'b1;
          end else begin
            hold_nx_s = hold_r + HOLD_W'(1);
          end
        end else begin
          state_nx_s = ST_PRESSED;
        end
      end
      ST_HELD: begin
        if (fall_s) begin
          state_nx_s = ST_RELEASED;
        end else begin
          state_nx_s = ST_HELD;
        end
      end
      default: begin
        state_nx_s = ST_RELEASED;
        hold_nx_s  = '0;
      end
    endcase
  end

  // Classifier state, hold counter and registered classification pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_RELEASED;
      hold_r  <= '0;
      short_r <= 1'b0;
      long_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      hold_r  <= hold_nx_s;
      short_r <= short_nx_s;
      long_r  <= long_nx_s;
    end
  end

  assign btn_level     = level_r;
  assign press_pulse   = press_r;
  assign release_pulse = release_r;
  assign short_pulse   = short_r;
  assign long_pulse    = long_r;

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Input-side counterpart to the board's reset and LED output logic: conditions one raw, asynchronous push-button pin into a clean debounced level plus one-cycle event pulses.
- Internal prescaler sets the sample rate; a per-sample stability counter filters bounce.
- A three-state FSM classifies each press as short or long.
- Sits between a board pin and the user logic, in the same top level as the power-on reset.

Parameters:
- SAMPLE_DIV, 16, prescaler width; one sample tick every 2^SAMPLE_DIV clk cycles; legal >= 1.
- STABLE_CNT, 4, consecutive differing samples required to change the debounced level; legal >= 1.
- LONG_SAMPLES, 256, debounced-pressed samples before long_pulse fires; legal >= 2.
- ACTIVE_LOW, 1, 1 means pin low = pressed; 0 means pin high = pressed.

Ports:
- clk  input  1  single system clock; all flops rise on posedge.
- rstn  input  1  asynchronous, active-low reset; async assert, release sampled on clk.
- btn_in  input  1  raw button pin, asynchronous to clk, may bounce.
- btn_level  output  1  debounced level, 1 = pressed.
- press_pulse  output  1  one-clk pulse on debounced press.
- release_pulse  output  1  one-clk pulse on debounced release.
- short_pulse  output  1  one-clk pulse on a release that occurs before long_pulse fired.
- long_pulse  output  1  one-clk pulse when the hold reaches LONG_SAMPLES samples.

Behaviour:
- Reset (rstn=0, asynchronous):
  - synchronizer flops are loaded with the pin's inactive value (ACTIVE_LOW ? 1 : 0);
  - prescaler, stability counter and hold counter are cleared;
  - FSM enters RELEASED;
  - all outputs are 0.
- Synchronizer: two flops, btn_in -> s1 -> s2. raw = s2 XOR ACTIVE_LOW, so raw=1 means pressed. Two-clk synchronizer latency.
- Prescaler:
  - SAMPLE_DIV-bit free-running counter, increments every clk, wraps from all-ones to 0.
  - tick is high for exactly the one clk in which the counter is all-ones.
  - First tick after reset occurs at clk 2^SAMPLE_DIV.
- Stability filter, evaluated on tick only:
  - raw == btn_level: stability counter cleared.
  - raw != btn_level and counter == STABLE_CNT-1: btn_level toggles at that edge and the counter clears.
  - raw != btn_level otherwise: counter increments.
  - A single agreeing sample restarts the count, so bounce shorter than STABLE_CNT samples never changes btn_level.
- Pulses:
  - press_pulse / release_pulse are registered and high in the same clk that btn_level goes 0->1 / 1->0.
  - They never overlap; minimum spacing is STABLE_CNT ticks.
- FSM states: RELEASED, PRESSED, HELD.
  - RELEASED -> PRESSED on debounced press; hold counter cleared.
  - PRESSED, hold counter:
    - increments on each tick while btn_level=1;
    - on the tick where the hold counter == LONG_SAMPLES-1, long_pulse is high for one clk and the FSM moves to HELD.
  - PRESSED -> RELEASED on debounced release: release_pulse and short_pulse are high in the same clk.
  - HELD -> RELEASED on debounced release: release_pulse only, no short_pulse.
  - HELD holds indefinitely; long_pulse fires at most once per press.
- Simultaneous events: if a debounced release and the long threshold land on the same tick, the release wins. Outputs are release_pulse + short_pulse, no long_pulse, next state RELEASED.
- Hold counter width: clog2(LONG_SAMPLES), saturating; it cannot wrap.
- Reset mid-press: all state is cleared immediately with no pulses emitted.
  - If the button is still held after rstn rises, press_pulse follows after normal synchronizer + STABLE_CNT-tick latency.
- Steady-state press latency: 2 clk synchronizer + STABLE_CNT ticks, i.e. (STABLE_CNT-1)*2^SAMPLE_DIV < latency <= STABLE_CNT*2^SAMPLE_DIV + 2 clk.

Test Plan:
Bench parameters: SAMPLE_DIV=2 (tick every 4 clk), STABLE_CNT=3, LONG_SAMPLES=5, ACTIVE_LOW=1.
- Reset: hold rstn=0 with btn_in=0 (pressed), then release rstn -> all outputs 0 during reset; press_pulse + btn_level=1 within 14 clk of release, never earlier than 9 clk.
- Bounce rejection: drive btn_in low for 6 clk, high for 6 clk, repeated 5 times -> btn_level stays 0, no pulses.
- Clean short press: btn_in low for 20 clk, then high -> one press_pulse; later one release_pulse and one short_pulse in the same clk; long_pulse stays 0.
- Long press: btn_in low for 60 clk -> press_pulse, then long_pulse exactly 5 ticks (20 clk) after press_pulse; on release, release_pulse only.
- Release/long collision: release btn_in so that the 3rd differing sample coincides with the 5th hold tick -> release_pulse + short_pulse, no long_pulse, FSM in RELEASED.
- Async reset mid-hold: assert rstn=0 for 1 clk while in HELD -> outputs 0 immediately, no pulse; button still low, so press_pulse reappears after normal debounce latency.
